multi_channel_timestamp_fifo: RTL and testbench

- N-channel event timestamper built around one free-running pWIDTH-bit cycle counter.
- Each channel synchronises an asynchronous event input and detects its rising edge. On each edge it writes a latency-compensated timestamp into a per-channel FIFO, so several events queue instead of blocking a single latch.
- A shared read port with channel select and valid/ack handshake drains the FIFOs toward the USB transfer logic.

---
 rtl/multi_channel_timestamp_fifo_if.sv | 35 +++
 rtl/multi_channel_timestamp_fifo.sv | 142 ++++++++++++++
 tb/tb_multi_channel_timestamp_fifo.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_timestamp_fifo_if.sv
// Read/status bus of the multi-channel timestamp FIFO: channel select, pop/clear handshake and flags.
// With TS_DROP_COUNT_EN defined the bus also carries the per-channel drop count of the selected channel.
interface multi_channel_timestamp_fifo_if #(
    parameter int pCHANNELS = 2,
    parameter int pWIDTH    = 64
);
    localparam int pSelW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;

    logic [pSelW-1:0]     iRdSel;
    logic                 iRdAck;
    logic                 iClrOverflow;
    logic [pWIDTH-1:0]    oRdData;
    logic                 oRdValid;
    logic [pCHANNELS-1:0] oPending;
    logic [pCHANNELS-1:0] oOverflow;
`ifdef TS_DROP_COUNT_EN
    logic [15:0]          oDropCount;
`endif

    modport master (
        output iRdSel, iRdAck, iClrOverflow,
`ifdef TS_DROP_COUNT_EN
        input  oDropCount,
`endif
        input  oRdData, oRdValid, oPending, oOverflow
    );

    modport slave (
        input  iRdSel, iRdAck, iClrOverflow,
`ifdef TS_DROP_COUNT_EN
        output oDropCount,
`endif
        output oRdData, oRdValid, oPending, oOverflow
    );
endinterface

// File: rtl/multi_channel_timestamp_fifo.sv
// N-channel event timestamper: shared free-running counter, per-channel synchroniser and FIFO.
// Optional macro TS_DROP_COUNT_EN adds a saturating 16-bit dropped-event counter per channel.
module multi_channel_timestamp_fifo #(
    parameter int pCHANNELS = 2,
    parameter int pWIDTH    = 64,
    parameter int pDEPTH    = 4,
    parameter int pSYNC     = 2
) (
    input  logic                          globalClock,
    input  logic                          iRst_n,
    input  logic [pCHANNELS-1:0]          iEvent,
    multi_channel_timestamp_fifo_if.slave rdPort,
    output logic [pWIDTH-1:0]             oCounter,
    output logic                          oWrap
);
    localparam int pSelW  = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;
    localparam int pAddrW = $clog2(pDEPTH);
    localparam logic [pAddrW:0] cPtrOne = (pAddrW + 1)'(1);

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    logic [pWIDTH-1:0]                   counter;
    logic                                wrap;
    logic [pWIDTH-1:0]                   stamp_p1;
    logic [pCHANNELS-1:0]                pendingVec;
    logic [pCHANNELS-1:0]                overflowVec;
    logic [pCHANNELS-1:0][pWIDTH-1:0]    headVec;
`ifdef TS_DROP_COUNT_EN
    logic [pCHANNELS-1:0][15:0]          dropVec;
`endif

    always_ff @(posedge globalClock) begin
        if (!iRst_n) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else begin
            counter <= counter + pWIDTH'(1);
            wrap    <= (counter == '1);
        end
    end

    assign oCounter = counter;
    assign oWrap    = wrap;

    // Stamp stage: an edge seen at the chain output was sampled pSYNC cycles ago
    always_ff @(posedge globalClock) begin
        stamp_p1 <= counter - pWIDTH'(pSYNC);
    end

    for (genvar ch = 0; ch < pCHANNELS; ch++) begin : gCh
        localparam logic [pSelW-1:0] cSel = pSelW'(ch);

        logic [pSYNC-1:0]  syncChain;
        logic              armLow;
        logic              vld_p1;
        logic              overflow;
        logic [pAddrW:0]   wPtr;
        logic [pAddrW:0]   rPtr;
        logic [pWIDTH-1:0] mem [pDEPTH];
        logic              sel, empty, full, pop, push, drop;

        assign sel   = (rdPort.iRdSel == cSel);
        assign empty = (wPtr == rPtr);
        assign full  = (wPtr[pAddrW] != rPtr[pAddrW]) &&
                       (wPtr[pAddrW-1:0] == rPtr[pAddrW-1:0]);
        assign pop   = sel && rdPort.iRdAck && !empty;
        assign push  = vld_p1 && (!full || pop);
        assign drop  = vld_p1 && full && !pop;

        always_ff @(posedge globalClock) begin
            syncChain <= {syncChain[pSYNC-2:0], iEvent[ch]};
        end

        // Edge stage: armLow is cleared by reset, so a level held high across release never fires
        always_ff @(posedge globalClock) begin
            if (!iRst_n) begin
                armLow   <= 1'b0;
                vld_p1   <= 1'b0;
                wPtr     <= '0;
                rPtr     <= '0;
                overflow <= 1'b0;
            end else begin
                armLow <= ~syncChain[pSYNC-1];
                vld_p1 <= syncChain[pSYNC-1] & armLow;
                if (push) wPtr <= wPtr + cPtrOne;
                if (pop)  rPtr <= rPtr + cPtrOne;
                if (drop)
                    overflow <= 1'b1;
                else if (sel && rdPort.iClrOverflow)
                    overflow <= 1'b0;
            end
        end

        // Write stage
        always_ff @(posedge globalClock) begin
            if (push) mem[wPtr[pAddrW-1:0]] <= stamp_p1;
        end

        assign pendingVec[ch]  = !empty;
        assign overflowVec[ch] = overflow;
        assign headVec[ch]     = mem[rPtr[pAddrW-1:0]];

`ifdef TS_DROP_COUNT_EN
        logic [15:0] dropCnt;

        always_ff @(posedge globalClock) begin
            if (!iRst_n)
                dropCnt <= '0;
            else if (sel && rdPort.iClrOverflow)
                dropCnt <= drop ? 16'd1 : 16'd0;
            else if (drop)
                dropCnt <= satInc16(dropCnt);
        end

        assign dropVec[ch] = dropCnt;
`endif
    end

    assign rdPort.oPending  = pendingVec;
    assign rdPort.oOverflow = overflowVec;

    always_comb begin
        rdPort.oRdData  = '0;
        rdPort.oRdValid = 1'b0;
`ifdef TS_DROP_COUNT_EN
        rdPort.oDropCount = '0;
`endif
        for (int c = 0; c < pCHANNELS; c++) begin
            if (rdPort.iRdSel == pSelW'(c)) begin
`ifdef TS_DROP_COUNT_EN
                rdPort.oDropCount = dropVec[c];
`endif
                if (pendingVec[c]) begin
                    rdPort.oRdData  = headVec[c];
                    rdPort.oRdValid = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_channel_timestamp_fifo.sv
// Directed bench for multi_channel_timestamp_fifo with a per-channel scoreboard of expected timestamps.
module tb_multi_channel_timestamp_fifo;
    localparam int pCHANNELS = 2;
    localparam int pWIDTH    = 16;
    localparam int pDEPTH    = 4;
    localparam int pSYNC     = 2;

    logic                 globalClock = 1'b0;
    logic                 iRst_n;
    logic [pCHANNELS-1:0] iEvent;
    logic [pWIDTH-1:0]    oCounter;
    logic                 oWrap;

    int checks = 0;
    int errors = 0;
    int expDrops0 = 0;
    logic [15:0] sb0[$];
    logic [15:0] sb1[$];

    always #5 globalClock = ~globalClock;

    multi_channel_timestamp_fifo_if #(.pCHANNELS(pCHANNELS), .pWIDTH(pWIDTH)) rdBus ();

    multi_channel_timestamp_fifo #(
        .pCHANNELS(pCHANNELS), .pWIDTH(pWIDTH), .pDEPTH(pDEPTH), .pSYNC(pSYNC)
    ) dut (
        .globalClock(globalClock),
        .iRst_n     (iRst_n),
        .iEvent     (iEvent),
        .rdPort     (rdBus),
        .oCounter   (oCounter),
        .oWrap      (oWrap)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge globalClock);
    endtask

    task automatic doReset();
        iRst_n = 1'b0;
        step();
        step();
        iRst_n = 1'b1;
        sb0.delete();
        sb1.delete();
        expDrops0 = 0;
    endtask

    task automatic waitCount(input logic [15:0] target);
        int n = 0;
        while (oCounter !== target && n < 70000) begin
            step();
            n++;
        end
        if (oCounter !== target) check("waitCount", oCounter, target);
    endtask

    // Reference model of a write without a same-cycle pop: dropped when the FIFO is full
    task automatic expectEvent(input int ch, input logic [15:0] ts);
        if (ch == 0) begin
            if (sb0.size() < pDEPTH) sb0.push_back(ts);
            else expDrops0++;
        end else begin
            if (sb1.size() < pDEPTH) sb1.push_back(ts);
        end
    endtask

    task automatic pulse(input int ch, input logic [15:0] at);
        waitCount(at);
        iEvent[ch] = 1'b1;
        expectEvent(ch, at);
        repeat (3) step();
        iEvent[ch] = 1'b0;
    endtask

    task automatic readCheck(input int ch, input string tag);
        logic [15:0] exp;
        exp = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
        rdBus.iRdSel = 1'(ch);
        #1;
        check({tag, "_valid"}, rdBus.oRdValid, 1);
        check({tag, "_data"}, rdBus.oRdData, exp);
        rdBus.iRdAck = 1'b1;
        step();
        rdBus.iRdAck = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst_n = 1'b0;
        iEvent = '0;
        rdBus.iRdSel = '0;
        rdBus.iRdAck = 1'b0;
        rdBus.iClrOverflow = 1'b0;

        // 1: reset state and idle counting
        doReset();
        #1;
        check("rst_counter", oCounter, 0);
        check("rst_wrap", oWrap, 0);
        check("rst_pending", rdBus.oPending, 0);
        check("rst_overflow", rdBus.oOverflow, 0);
        check("rst_valid", rdBus.oRdValid, 0);
        check("rst_data", rdBus.oRdData, 0);
`ifdef TS_DROP_COUNT_EN
        check("rst_dropcnt", rdBus.oDropCount, 0);
`endif
        for (int i = 0; i < 300; i++) begin
            check("idle_counter", oCounter, 64'(i));
            check("idle_flags", {oWrap, rdBus.oPending, rdBus.oRdValid}, 0);
            step();
        end

        // 2: single event, exact write latency and show-ahead read
        doReset();
        waitCount(16'd100);
        iEvent[0] = 1'b1;
        expectEvent(0, 16'd100);
        for (int i = 1; i <= pSYNC + 2; i++) begin
            step();
            if (i == 3) iEvent[0] = 1'b0;
            check("t2_pending", rdBus.oPending[0], (i == pSYNC + 2) ? 1 : 0);
        end
        readCheck(0, "t2_read");
        check("t2_empty", rdBus.oRdValid, 0);

        // 3: simultaneous edges on both channels
        waitCount(16'd500);
        iEvent = 2'b11;
        expectEvent(0, 16'd500);
        expectEvent(1, 16'd500);
        repeat (3) step();
        iEvent = 2'b00;
        repeat (3) step();
        check("t3_pending", rdBus.oPending, 2'b11);
        readCheck(1, "t3_ch1");
        readCheck(0, "t3_ch0");
        check("t3_drained", rdBus.oPending, 0);

        // 4: overflow on a full FIFO, then clear
        doReset();
        for (int k = 1; k <= 6; k++) pulse(0, 16'(10 * k));
        repeat (5) step();
        check("t4_overflow", rdBus.oOverflow, 2'b01);
        check("t4_pending", rdBus.oPending, 2'b01);
`ifdef TS_DROP_COUNT_EN
        rdBus.iRdSel = 1'b0;
        #1;
        check("t4_dropcnt", rdBus.oDropCount, 64'(expDrops0));
`endif
        for (int k = 0; k < pDEPTH; k++) readCheck(0, "t4_read");
        check("t4_empty", rdBus.oRdValid, 0);
        rdBus.iRdSel = 1'b0;
        rdBus.iClrOverflow = 1'b1;
        step();
        rdBus.iClrOverflow = 1'b0;
        #1;
        check("t4_ovf_clear", rdBus.oOverflow, 0);
`ifdef TS_DROP_COUNT_EN
        check("t4_dropcnt_clear", rdBus.oDropCount, 0);
`endif
        // ack on an empty FIFO must not disturb the pointers
        rdBus.iRdAck = 1'b1;
        step();
        rdBus.iRdAck = 1'b0;
        check("t4_ack_empty", rdBus.oPending, 0);
        pulse(0, 16'd150);
        repeat (2) step();
        readCheck(0, "t4_after_ack");

        // 4b: full FIFO with a pop in the write cycle keeps every event
        for (int k = 0; k < pDEPTH; k++) pulse(1, 16'(200 + 10 * k));
        waitCount(16'd240);
        iEvent[1] = 1'b1;
        repeat (3) step();
        iEvent[1] = 1'b0;
        rdBus.iRdSel = 1'b1;
        rdBus.iRdAck = 1'b1;
        #1;
        check("t4b_pop_valid", rdBus.oRdValid, 1);
        check("t4b_pop_data", rdBus.oRdData, sb1.pop_front());
        sb1.push_back(16'd240);
        step();
        rdBus.iRdAck = 1'b0;
        #1;
        check("t4b_no_overflow", rdBus.oOverflow, 0);
        for (int k = 0; k < pDEPTH; k++) readCheck(1, "t4b_read");
        check("t4b_empty", rdBus.oRdValid, 0);

        // 5: counter wrap and timestamp next to it
        doReset();
        waitCount(16'hFFFE);
        iEvent[0] = 1'b1;
        expectEvent(0, 16'hFFFE);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 3) iEvent[0] = 1'b0;
            check("t5_counter", oCounter, 64'(16'(16'hFFFE + i)));
            check("t5_wrap", oWrap, (i == 2) ? 1 : 0);
        end
        readCheck(0, "t5_read");

        // 6: level held across reset release, then mid-operation reset
        iEvent[1] = 1'b1;
        doReset();
        repeat (20) step();
        check("t6_held_high", rdBus.oPending, 0);
        iEvent[1] = 1'b0;
        pulse(1, 16'd40);
        repeat (5) step();
        check("t6_one_entry", rdBus.oPending, 2'b10);
        readCheck(1, "t6_read");
        check("t6_only_one", rdBus.oPending, 0);
        pulse(0, 16'd60);
        pulse(0, 16'd70);
        pulse(0, 16'd80);
        repeat (5) step();
        check("t6_queued", rdBus.oPending, 2'b01);
        iRst_n = 1'b0;
        step();
        sb0.delete();
        #1;
        check("t6_rst_pending", rdBus.oPending, 0);
        check("t6_rst_counter", oCounter, 0);
        rdBus.iRdSel = 1'b0;
        #1;
        check("t6_rst_valid", rdBus.oRdValid, 0);
        check("t6_rst_data", rdBus.oRdData, 0);
        iRst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
